quad_enc_ctrl: RTL

QUAD_ENC_CTRL -- requirements
Module: quad_enc_ctrl

---
 rtl/quad_enc_pkg.sv | 33 +++
 rtl/sig_filter.sv | 39 +++
 rtl/quad_enc_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/quad_enc_pkg.sv
// Shared types for the quadrature encoder controller: decoder states and direction codes.
package quad_enc_pkg;

    // State encoding is the filtered {a,b} pair itself.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } qstate_t;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    function automatic qstate_t cw_next(input qstate_t s);
        case (s)
            S00:     cw_next = S10;
            S10:     cw_next = S11;
            S11:     cw_next = S01;
            default: cw_next = S00;
        endcase
    endfunction

    function automatic qstate_t ccw_next(input qstate_t s);
        case (s)
            S00:     ccw_next = S01;
            S01:     ccw_next = S11;
            S11:     ccw_next = S10;
            default: ccw_next = S00;
        endcase
    endfunction

endpackage

// File: rtl/sig_filter.sv
// Two-flop synchronizer followed by a stability filter that accepts a new level
// only after N consecutive differing samples.
module sig_filter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o
);

    localparam int CW = $clog2(N + 1);

    logic [1:0]    sync_q;
    logic          out_q;
    logic [CW-1:0] cnt_q;

    // The count saturates by construction: it is reset on acceptance at N-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], din_i};
            if (sync_q[1] == out_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(N - 1)) begin
                out_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout_o = out_q;

endmodule

// File: rtl/quad_enc_ctrl.sv
// Quadrature decoder with x4 position counter, sticky illegal-step flag and
// debounced push-button with press pulse.
module quad_enc_ctrl
    import quad_enc_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int ENC_FILT = 4,
    parameter int KEY_DB   = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             key,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             key_lvl,
    output logic             key_press
);

    logic    a_f, b_f, key_f;
    qstate_t st_q, st_d;
    qstate_t ab;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic    dir_q, dir_d, step_q, step_d, err_q, err_d;
    logic    key_prev_q, press_q;

    sig_filter #(.N(ENC_FILT)) u_filt_a   (.clk(clk), .rst(rst), .din_i(enc_a), .dout_o(a_f));
    sig_filter #(.N(ENC_FILT)) u_filt_b   (.clk(clk), .rst(rst), .din_i(enc_b), .dout_o(b_f));
    sig_filter #(.N(KEY_DB))   u_filt_key (.clk(clk), .rst(rst), .din_i(key),   .dout_o(key_f));

    assign ab = qstate_t'({a_f, b_f});

    always_comb begin
        st_d   = ab;
        pos_d  = pos_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        err_d  = err_q;
        if (ab != st_q) begin
            if (ab == cw_next(st_q)) begin
                step_d = 1'b1;
                dir_d  = DIR_CW;
                pos_d  = pos_q + 1'b1;
            end else if (ab == ccw_next(st_q)) begin
                step_d = 1'b1;
                dir_d  = DIR_CCW;
                pos_d  = pos_q - 1'b1;
            end else begin
                err_d  = 1'b1;
            end
        end
        // Clear overrides any coincident count or error, but not step/dir.
        if (cnt_clr) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= S00;
            pos_q      <= '0;
            dir_q      <= DIR_CW;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            key_prev_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            st_q       <= st_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
            key_prev_q <= key_f;
            press_q    <= key_f & ~key_prev_q;
        end
    end

    assign pos       = pos_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign err       = err_q;
    assign key_lvl   = key_f;
    assign key_press = press_q;

endmodule
